// File: rtl/dlatch_bank_pkg.sv
// Shared types for dlatch_bank: scanner FSM states, MODE encodings and a wrap helper.
package dlatch_bank_pkg;

  localparam int MODE_REG    = 0;
  localparam int MODE_TRANSP = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    PRESENT = 2'd2
  } scan_state_e;

  // (a + b) mod n, valid for a, b < n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/dlatch_bank_rr_pick.sv
// Round-robin picker: first set bit of chg at or after ptr, wrapping CHANNELS-1 -> 0.
module dlatch_bank_rr_pick
  import dlatch_bank_pkg::*;
#(
  parameter int CHANNELS = 4,
  localparam int IW = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] chg,
  input  logic [IW-1:0]       ptr,
  output logic                found,
  output logic [IW-1:0]       idx
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    found = |chg;
    idx   = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (chg[IW'(wrap_add(int'(ptr), k, CHANNELS))]) begin
        idx = IW'(wrap_add(int'(ptr), k, CHANNELS));
      end
    end
  end

endmodule

// File: rtl/dlatch_bank.sv
// Bank of per-channel data holders with a round-robin change-event scanner.
// Optional macro DLATCH_BANK_PARITY_EN adds evt_par (XOR of evt_data).
module dlatch_bank
  import dlatch_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_REG,
  localparam int IW = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       En,
  input  logic [CHANNELS*WIDTH-1:0] D,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS*WIDTH-1:0] not_Q,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [IW-1:0]             evt_ch,
  output logic [WIDTH-1:0]          evt_data,
`ifdef DLATCH_BANK_PARITY_EN
  output logic                      evt_par,
`endif
  output scan_state_e               dbg_state
);

  logic [CHANNELS-1:0][WIDTH-1:0] held_q, held_d, q_w;
  logic [CHANNELS-1:0]            chg_q, chg_d, set_vec, clr_vec;
  logic [IW-1:0]                  ptr_q, ptr_d, evt_ch_q, evt_ch_d, pick_idx;
  logic [WIDTH-1:0]               evt_data_q, evt_data_d;
  logic                           rearm_q, rearm_d, pick_found;
  scan_state_e                    state_q, state_d;

  always_comb begin
    held_d  = held_q;
    set_vec = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (En[i]) begin
        held_d[i]  = D[i*WIDTH +: WIDTH];
        set_vec[i] = (D[i*WIDTH +: WIDTH] != held_q[i]);
      end
    end
  end

  generate
    if (MODE == MODE_TRANSP) begin : g_transp
      always_comb begin
        q_w = held_q;
        for (int i = 0; i < CHANNELS; i++) begin
          if (En[i]) q_w[i] = D[i*WIDTH +: WIDTH];
        end
      end
    end else begin : g_reg
      assign q_w = held_q;
    end
  endgenerate

  assign Q     = q_w;
  assign not_Q = ~q_w;

  dlatch_bank_rr_pick #(.CHANNELS(CHANNELS)) u_pick (
    .chg   (chg_q),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Event handshake: evt_valid is high only in PRESENT; evt_ch/evt_data are frozen
  // there and the event is consumed on the first edge with evt_valid && evt_ready.
  // rearm_q remembers a differing reload of the presented channel so acceptance
  // does not clear a change the consumer has not yet seen.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    evt_ch_d   = evt_ch_q;
    evt_data_d = evt_data_q;
    rearm_d    = rearm_q;
    clr_vec    = '0;
    case (state_q)
      IDLE: begin
        if (|chg_q) state_d = SELECT;
      end
      SELECT: begin
        if (pick_found) begin
          evt_ch_d   = pick_idx;
          evt_data_d = held_q[pick_idx];
          rearm_d    = set_vec[pick_idx];
          state_d    = PRESENT;
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        rearm_d = rearm_q | set_vec[evt_ch_q];
        if (evt_ready) begin
          state_d = IDLE;
          rearm_d = 1'b0;
          if (!rearm_q) clr_vec[evt_ch_q] = 1'b1;
          ptr_d = (evt_ch_q == IW'(CHANNELS - 1)) ? '0 : evt_ch_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    chg_d = set_vec | (chg_q & ~clr_vec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q     <= '0;
      chg_q      <= '0;
      ptr_q      <= '0;
      evt_ch_q   <= '0;
      evt_data_q <= '0;
      rearm_q    <= 1'b0;
      state_q    <= IDLE;
    end else begin
      held_q     <= held_d;
      chg_q      <= chg_d;
      ptr_q      <= ptr_d;
      evt_ch_q   <= evt_ch_d;
      evt_data_q <= evt_data_d;
      rearm_q    <= rearm_d;
      state_q    <= state_d;
    end
  end

  assign evt_valid = (state_q == PRESENT);
  assign evt_ch    = evt_ch_q;
  assign evt_data  = evt_data_q;
  assign dbg_state = state_q;

`ifdef DLATCH_BANK_PARITY_EN
  logic evt_par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_par_q <= 1'b0;
    end else if (state_q == SELECT && pick_found) begin
      evt_par_q <= ^held_q[pick_idx];
    end
  end

  assign evt_par = evt_par_q;
`endif

endmodule
